// File: rtl/calc_pkg.sv
// Shared definitions for the keypad scanner, key filter and calculator core.
// Holds the debounce FSM encoding, key-code constants and the counter helper.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kf_state_e;

  localparam int unsigned CNT_W = 24;

  localparam logic [3:0] KEY_0   = 4'h0;
  localparam logic [3:0] KEY_1   = 4'h1;
  localparam logic [3:0] KEY_2   = 4'h2;
  localparam logic [3:0] KEY_3   = 4'h3;
  localparam logic [3:0] KEY_4   = 4'h4;
  localparam logic [3:0] KEY_5   = 4'h5;
  localparam logic [3:0] KEY_6   = 4'h6;
  localparam logic [3:0] KEY_7   = 4'h7;
  localparam logic [3:0] KEY_8   = 4'h8;
  localparam logic [3:0] KEY_9   = 4'h9;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  // Saturating increment: the debounce counter must never wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + 24'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a per-bit reset value
// so idle lines come out of reset in their inactive state.
module sync_2ff #(
  parameter int unsigned  W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;

  // Two-stage capture of the raw inputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_meta <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/key_filter.sv
// Keypad debouncer: accepts a press or release only after DEB_CYCLES stable
// synchronized cycles, then emits one key_valid pulse per accepted press.
module key_filter
  import calc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       key_in,
  input  logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] key_value,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [4:0]       w_sync;
  logic             w_key_in;
  logic [3:0]       w_code;

  kf_state_e        r_state;
  kf_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_cand;
  logic [3:0]       w_cand_nxt;
  logic             w_valid_nxt;
  logic [3:0]       w_value_nxt;
  logic             w_held_nxt;

  sync_2ff #(
    .W       (5),
    .RST_VAL (5'b1_0000)
  ) u_sync (
    .Clk (Clk),
    .Rst (Rst),
    .i_d ({key_in, key_code}),
    .o_q (w_sync)
  );

  assign w_key_in = w_sync[4];
  assign w_code   = w_sync[3:0];

  // Next-state, counter, candidate and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_valid_nxt = 1'b0;
    w_value_nxt = key_value;
    case (r_state)
      ST_IDLE: begin
        if (!w_key_in) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = 24'd0;
          w_cand_nxt  = w_code;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (w_key_in) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 24'd0;
        end else if (w_code != r_cand) begin
          w_cand_nxt = w_code;
          w_cnt_nxt  = 24'd0;
        end else if (r_cnt >= LP_LAST) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = 24'd0;
          w_value_nxt = r_cand;
          w_valid_nxt = 1'b1;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      ST_HELD: begin
        // Code changes while still held are deliberately ignored.
        if (w_key_in) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = 24'd0;
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!w_key_in) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = 24'd0;
        end else if (r_cnt >= LP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 24'd0;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 24'd0;
      end
    endcase
    w_held_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_WAIT);
  end

  // State and registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 24'd0;
      r_cand    <= 4'h0;
      key_valid <= 1'b0;
      key_value <= 4'h0;
      key_held  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cand    <= w_cand_nxt;
      key_valid <= w_valid_nxt;
      key_value <= w_value_nxt;
      key_held  <= w_held_nxt;
    end
  end

endmodule
